// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4-Lite read master between instr (port 0) and data (port 1), one transaction at a time
// Define AXI_RD_ARB_RR_EN for round-robin tie-breaking; otherwise port 1 wins ties.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             s_arvalid,
  output logic [1:0]             s_arready,
  input  logic [1:0][ADDR_W-1:0] s_araddr,
  input  logic [1:0][2:0]        s_arprot,
  output logic [1:0]             s_rvalid,
  input  logic [1:0]             s_rready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [ADDR_W-1:0]      m_araddr,
  output logic [2:0]             m_arprot,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic [1:0]             m_rresp
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nxt;
  logic gnt, g, take;
  assign take = state == IDLE && |s_arvalid;
`ifdef AXI_RD_ARB_RR_EN
  logic last;
  assign g = &s_arvalid ? ~last : s_arvalid[1];
  always_ff @(posedge clk)
    if (reset) last <= 1'b1;
    else if (take) last <= g;
`else
  assign g = s_arvalid[1];
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (take ? ADDR : IDLE) :
                state == ADDR ? (m_arready ? DATA : ADDR) :
                (m_rvalid && m_rready ? IDLE : DATA);
  always_ff @(posedge clk)
    if (reset) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arprot  <= '0;
      gnt       <= 1'b0;
    end else begin
      m_arvalid <= take | (m_arvalid & ~m_arready);
      if (take) begin
        m_araddr <= s_araddr[g];
        m_arprot <= s_arprot[g];
        gnt      <= g;
      end
    end
  always_comb begin
    s_arready = take ? (g ? 2'b10 : 2'b01) : 2'b00;
    m_rready  = state == DATA && s_rready[gnt];
    s_rvalid  = (state == DATA && m_rvalid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    s_rdata   = state == DATA ? m_rdata : '0;
    s_rresp   = state == DATA ? m_rresp : '0;
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed checks of grant, routing, stalls, error response and mid-transaction reset
module tb_axi_rd_arbiter;
  localparam logic [2:0] P0 = 3'b100, P1 = 3'b011;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_rresp, m_rresp;
  logic [1:0][31:0] s_araddr;
  logic [1:0][2:0] s_arprot;
  logic [31:0] s_rdata, m_araddr, m_rdata;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0] m_arprot;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  task automatic serve(input int p, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] resp, input int ar_wait, input int r_stall, input bit hold);
    logic [1:0] oh;
    oh = 2'b01 << p;
    #1 check("arready_grant", s_arready, oh);
    tick;
    if (!hold) s_arvalid[p] = 1'b0;
    #1;
    check("m_arvalid_set", m_arvalid, 1);
    check("m_araddr", m_araddr, addr);
    check("m_arprot", m_arprot, p ? P1 : P0);
    check("arready_busy", s_arready, 0);
    repeat (ar_wait) begin
      tick;
      check("m_arvalid_hold", m_arvalid, 1);
      check("m_araddr_hold", m_araddr, addr);
    end
    m_arready = 1'b1;
    tick;
    m_arready = 1'b0;
    #1;
    check("m_arvalid_clr", m_arvalid, 0);
    check("rvalid_before_data", s_rvalid, 0);
    m_rvalid = 1'b1;
    m_rdata  = data;
    m_rresp  = resp;
    repeat (r_stall) begin
      #1;
      check("m_rready_stall", m_rready, 0);
      check("s_rvalid_stall", s_rvalid, oh);
      check("s_rdata_stall", s_rdata, data);
      tick;
    end
    s_rready[p] = 1'b1;
    #1;
    check("m_rready", m_rready, 1);
    check("s_rvalid", s_rvalid, oh);
    check("s_rdata", s_rdata, data);
    check("s_rresp", s_rresp, resp);
    tick;
    m_rvalid = 1'b0;
    m_rdata = '0;
    m_rresp = '0;
    s_rready[p] = 1'b0;
    #1;
    check("s_rvalid_idle", s_rvalid, 0);
    check("m_rready_idle", m_rready, 0);
  endtask
  initial begin
    reset = 1'b1;
    s_arvalid = '0; s_rready = '0; s_araddr = '0; s_arprot = {P1, P0};
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    tick;
    tick;
    reset = 1'b0;
    #1;
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_m_araddr", m_araddr, 0);
    check("rst_m_arprot", m_arprot, 0);
    check("rst_s_arready", s_arready, 0);
    check("rst_s_rvalid", s_rvalid, 0);
    check("rst_m_rready", m_rready, 0);
    check("rst_s_rdata", s_rdata, 0);
    check("rst_s_rresp", s_rresp, 0);
    // single requester on port 0, memory slow to accept the address
    s_araddr[0] = 32'h0000_0100;
    s_arvalid = 2'b01;
    serve(0, 32'h100, 32'hDEAD_BEEF, 2'b00, 2, 0, 0);
    // simultaneous requests; fresh reset restores the round-robin pointer
    pulse_reset;
    s_araddr[1] = 32'h0000_2000;
    s_arvalid = 2'b11;
`ifdef AXI_RD_ARB_RR_EN
    serve(0, 32'h100, 32'h1111_0000, 2'b00, 0, 0, 0);
    serve(1, 32'h2000, 32'h2222_0000, 2'b00, 0, 0, 0);
`else
    serve(1, 32'h2000, 32'h2222_0000, 2'b00, 0, 0, 0);
    serve(0, 32'h100, 32'h1111_0000, 2'b00, 0, 0, 0);
`endif
    // both held for four transactions
    pulse_reset;
    s_arvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef AXI_RD_ARB_RR_EN
      serve(i % 2, (i % 2) ? 32'h2000 : 32'h100, 32'hA000_0000 + i, 2'b00, 0, 0, 1);
`else
      serve(1, 32'h2000, 32'hA000_0000 + i, 2'b00, 0, 0, 1);
`endif
    end
    s_arvalid = 2'b00;
    // error response forwarded to port 1
    s_arvalid = 2'b10;
    serve(1, 32'h2000, 32'h1234_5678, 2'b10, 0, 0, 0);
    check("slverr_idle_arvalid", m_arvalid, 0);
    check("slverr_idle_arready", s_arready, 0);
    // requester back-pressure on R
    s_arvalid = 2'b01;
    serve(0, 32'h100, 32'hCAFE_F00D, 2'b00, 1, 3, 0);
    // reset while in ADDR
    s_arvalid = 2'b01;
    #1 check("rst_mid_grant", s_arready, 2'b01);
    tick;
    s_arvalid = 2'b00;
    #1 check("rst_mid_arvalid", m_arvalid, 1);
    pulse_reset;
    #1;
    check("rst_mid_arvalid_clr", m_arvalid, 0);
    check("rst_mid_araddr", m_araddr, 0);
    check("rst_mid_arready", s_arready, 0);
    check("rst_mid_rready", m_rready, 0);
    s_araddr[0] = 32'h0000_0300;
    s_arvalid = 2'b01;
    serve(0, 32'h300, 32'h0BAD_F00D, 2'b00, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
